add_sub_serial: RTL and testbench



---
 rtl/add_sub_pkg.sv | 21 ++
 rtl/add_sub_serial_if.sv | 47 ++++
 rtl/add_sub_seg.sv | 22 ++
 rtl/add_sub_serial.sv | 151 +++++++++++++++
 tb/tb_add_sub_serial.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor.
// State encoding and the WIDTH/SEG legality check.
package add_sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A legal configuration splits WIDTH into whole SEG-bit segments.
  function automatic bit cfgLegal(
    input int width,
    input int seg
  );
    return (width >= 1) &&
           (seg >= 1) &&
           (seg <= width) &&
           ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/add_sub_serial_if.sv
// Request/result bundle for add_sub_serial.
// master: start + operands out, busy/done/flags in; slave: reverse.
interface add_sub_serial_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             c_in;
  logic             sub_notAdd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf;
  logic             zero;

  modport master (
    output start,
    output in1,
    output in2,
    output c_in,
    output sub_notAdd,
    input  busy,
    input  done,
    input  s,
    input  c,
    input  ovf,
    input  zero
  );

  modport slave (
    input  start,
    input  in1,
    input  in2,
    input  c_in,
    input  sub_notAdd,
    output busy,
    output done,
    output s,
    output c,
    output ovf,
    output zero
  );

endinterface

// File: rtl/add_sub_seg.sv
// One SEG-bit ripple slice of the serial adder.
// Ports: a, b, cin in; sum, cout out (purely combinational).
module add_sub_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] wide;

  assign wide = {1'b0, a}
              + {1'b0, b}
              + {{SEG{1'b0}}, cin};

  assign sum  = wide[SEG-1:0];
  assign cout = wide[SEG];

endmodule

// File: rtl/add_sub_serial.sv
// Multi-cycle add/sub: in1 + (in2 ^ {W{sub}}) + c_in, SEG bits per clock.
// Ports: clock, reset (sync, active-high), bus (slave: start/operands in; busy/done/s/c/ovf/zero out).
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 4
) (
  input logic           clock,
  input logic           reset,
  add_sub_serial_if.slave bus
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  localparam logic [IW-1:0] LAST = IW'(NSEG - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  generate
    if (!cfgLegal(WIDTH, SEG)) begin : g_badCfg
      $error("add_sub_serial: WIDTH must be a multiple of SEG");
    end
    if ($bits(bus.s) != WIDTH) begin : g_badBus
      $error("add_sub_serial: bus width differs from WIDTH");
    end
  endgenerate

  state_t state;
  state_t nextState;

  logic accept;
  logic lastSeg;

  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] workNext;

  logic [SEG-1:0] aSeg;
  logic [SEG-1:0] bSeg;
  logic [SEG-1:0] sumSeg;
  logic           coutSeg;

  logic             doneR;
  logic [WIDTH-1:0] sR;
  logic             cR;
  logic             ovfR;
  logic             zeroR;

  // ---------------- FSM ----------------

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    accept    = 1'b0;
    lastSeg   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        if (idx == LAST) begin
          lastSeg   = 1'b1;
          nextState = IDLE;
        end
      end
    endcase
  end

  // ---------------- segment slice ----------------

  assign aSeg = opA[int'(idx)*SEG +: SEG];
  assign bSeg = opB[int'(idx)*SEG +: SEG];

  add_sub_seg #(
    .SEG (SEG)
  ) u_seg (
    .a    (aSeg),
    .b    (bSeg),
    .cin  (carry),
    .sum  (sumSeg),
    .cout (coutSeg)
  );

  // The result word as it stands after this edge's segment lands;
  // the last edge publishes it directly so s never lags a cycle.
  always_comb begin
    workNext = work;
    workNext[int'(idx)*SEG +: SEG] = sumSeg;
  end

  // ---------------- datapath ----------------

  always_ff @(posedge clock) begin
    if (reset) begin
      idx   <= '0;
      carry <= 1'b0;
      opA   <= '0;
      opB   <= '0;
      work  <= '0;
      doneR <= 1'b0;
      sR    <= '0;
      cR    <= 1'b0;
      ovfR  <= 1'b0;
      zeroR <= 1'b0;
    end else begin
      doneR <= lastSeg;
      if (accept) begin
        opA   <= bus.in1;
        opB   <= bus.in2 ^ {WIDTH{bus.sub_notAdd}};
        carry <= bus.c_in;
        idx   <= '0;
      end else if (state == RUN) begin
        work  <= workNext;
        carry <= coutSeg;
        idx   <= lastSeg ? '0 : idx + ONE;
        if (lastSeg) begin
          sR    <= workNext;
          cR    <= coutSeg;
          // Same-sign operands giving an opposite-sign sum.
          ovfR  <= (opA[WIDTH-1] == opB[WIDTH-1]) &&
                   (workNext[WIDTH-1] != opA[WIDTH-1]);
          zeroR <= (workNext == '0);
        end
      end
    end
  end

  // ---------------- outputs ----------------

  assign bus.busy = (state == RUN);
  assign bus.done = doneR;
  assign bus.s    = sR;
  assign bus.c    = cR;
  assign bus.ovf  = ovfR;
  assign bus.zero = zeroR;

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial.
// Three instances: 32/4 (main), 32/32 and 8/2 (config sweep).
module tb_add_sub_serial;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int total = 0;
  int bad   = 0;

  add_sub_serial_if #(.WIDTH(32)) i0();
  add_sub_serial_if #(.WIDTH(32)) i1();
  add_sub_serial_if #(.WIDTH(8))  i2();

  add_sub_serial #(.WIDTH(32), .SEG(4)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (i0.slave)
  );

  add_sub_serial #(.WIDTH(32), .SEG(32)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (i1.slave)
  );

  add_sub_serial #(.WIDTH(8), .SEG(2)) dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (i2.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic doneOf(input int sel);
    case (sel)
      0:       return i0.done;
      1:       return i1.done;
      default: return i2.done;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Called at a negedge; returns edges until done (-1 on timeout)
  // and the number of sampled cycles with i0.busy high.
  task automatic waitDone(
    input  int sel,
    output int cyc,
    output int busyCnt
  );
    cyc     = -1;
    busyCnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (i0.busy) busyCnt++;
      if (doneOf(sel)) begin
        cyc = k;
        return;
      end
    end
  endtask

  task automatic countDones(
    input  int n,
    output int dones
  );
    dones = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (i0.done) dones++;
    end
  endtask

  task automatic launch0(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        ci,
    input logic        sb
  );
    i0.in1        = a;
    i0.in2        = b;
    i0.c_in       = ci;
    i0.sub_notAdd = sb;
    i0.start      = 1'b1;
    tick();
    i0.start      = 1'b0;
  endtask

  int cyc;
  int bc;
  int nd;

  initial begin
    i0.start = 0; i0.in1 = 0; i0.in2 = 0;
    i0.c_in = 0; i0.sub_notAdd = 0;
    i1.start = 0; i1.in1 = 0; i1.in2 = 0;
    i1.c_in = 0; i1.sub_notAdd = 0;
    i2.start = 0; i2.in1 = 0; i2.in2 = 0;
    i2.c_in = 0; i2.sub_notAdd = 0;

    // reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 64'(i0.busy), 64'd0);
    chk("rst_done", 64'(i0.done), 64'd0);
    chk("rst_s",    64'(i0.s),    64'd0);
    chk("rst_c",    64'(i0.c),    64'd0);
    chk("rst_ovf",  64'(i0.ovf),  64'd0);
    chk("rst_zero", 64'(i0.zero), 64'd0);
    reset = 1'b0;
    tick();

    // 5 + 3
    launch0(32'h5, 32'h3, 1'b0, 1'b0);
    bc = 0;
    if (i0.busy) bc = 1;
    waitDone(0, cyc, nd);
    bc += nd;
    chk("add_lat",  64'(cyc),     64'd8);
    chk("add_busy", 64'(bc),      64'd8);
    chk("add_s",    64'(i0.s),    64'h8);
    chk("add_c",    64'(i0.c),    64'd0);
    chk("add_ovf",  64'(i0.ovf),  64'd0);
    chk("add_zero", 64'(i0.zero), 64'd0);
    chk("add_bsy0", 64'(i0.busy), 64'd0);
    tick();
    chk("add_pulse", 64'(i0.done), 64'd0);
    chk("add_hold",  64'(i0.s),    64'h8);

    // 5 - 5
    launch0(32'h5, 32'h5, 1'b1, 1'b1);
    waitDone(0, cyc, nd);
    chk("sub_lat",  64'(cyc),     64'd8);
    chk("sub_s",    64'(i0.s),    64'h0);
    chk("sub_zero", 64'(i0.zero), 64'd1);
    chk("sub_c",    64'(i0.c),    64'd1);
    chk("sub_ovf",  64'(i0.ovf),  64'd0);
    tick();

    // full carry ripple
    launch0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    waitDone(0, cyc, nd);
    chk("rip_s",    64'(i0.s),    64'h0);
    chk("rip_c",    64'(i0.c),    64'd1);
    chk("rip_zero", 64'(i0.zero), 64'd1);
    chk("rip_ovf",  64'(i0.ovf),  64'd0);
    tick();

    // signed overflow
    launch0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    waitDone(0, cyc, nd);
    chk("ovf_s",    64'(i0.s),    64'h8000_0000);
    chk("ovf_ovf",  64'(i0.ovf),  64'd1);
    chk("ovf_c",    64'(i0.c),    64'd0);
    chk("ovf_zero", 64'(i0.zero), 64'd0);
    tick();

    // start during RUN is ignored, operands are don't-care
    launch0(32'h10, 32'h20, 1'b0, 1'b0);
    i0.start      = 1'b1;
    i0.in1        = 32'h1000;
    i0.in2        = 32'h2000;
    i0.c_in       = 1'b1;
    i0.sub_notAdd = 1'b1;
    repeat (3) tick();
    i0.start = 1'b0;
    waitDone(0, cyc, nd);
    chk("ign_lat", 64'(cyc + 3), 64'd8);
    chk("ign_s",   64'(i0.s),    64'h30);
    chk("ign_c",   64'(i0.c),    64'd0);
    countDones(10, nd);
    chk("ign_nodone", 64'(nd),   64'd0);
    chk("ign_idle",   64'(i0.busy), 64'd0);

    // back-to-back: start held in the done cycle
    launch0(32'h100, 32'h23, 1'b0, 1'b0);
    waitDone(0, cyc, nd);
    chk("b2b_lat1", 64'(cyc),  64'd8);
    chk("b2b_s1",   64'(i0.s), 64'h123);
    launch0(32'h50, 32'h10, 1'b1, 1'b1);
    chk("b2b_drop", 64'(i0.done), 64'd0);
    chk("b2b_busy", 64'(i0.busy), 64'd1);
    chk("b2b_hold", 64'(i0.s),    64'h123);
    waitDone(0, cyc, nd);
    chk("b2b_lat2", 64'(cyc),  64'd8);
    chk("b2b_s2",   64'(i0.s), 64'h40);
    chk("b2b_c2",   64'(i0.c), 64'd1);
    countDones(3, nd);
    chk("b2b_once", 64'(nd), 64'd0);

    // reset in the third RUN cycle
    launch0(32'h11, 32'h22, 1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", 64'(i0.busy), 64'd0);
    chk("mrst_done", 64'(i0.done), 64'd0);
    chk("mrst_s",    64'(i0.s),    64'd0);
    chk("mrst_c",    64'(i0.c),    64'd0);
    chk("mrst_ovf",  64'(i0.ovf),  64'd0);
    chk("mrst_zero", 64'(i0.zero), 64'd0);
    countDones(12, nd);
    chk("mrst_nodone", 64'(nd), 64'd0);
    launch0(32'h1234, 32'h1111, 1'b0, 1'b0);
    waitDone(0, cyc, nd);
    chk("mrst_lat", 64'(cyc),  64'd8);
    chk("mrst_s2",  64'(i0.s), 64'h2345);

    // WIDTH=32, SEG=32
    i1.in1   = 32'h1234_5678;
    i1.in2   = 32'h1111_1111;
    i1.start = 1'b1;
    tick();
    i1.start = 1'b0;
    waitDone(1, cyc, nd);
    chk("w32_lat", 64'(cyc),  64'd1);
    chk("w32_s",   64'(i1.s), 64'h2345_6789);
    chk("w32_c",   64'(i1.c), 64'd0);

    // WIDTH=8, SEG=2: 0x80 - 0x01
    i2.in1        = 8'h80;
    i2.in2        = 8'h01;
    i2.c_in       = 1'b1;
    i2.sub_notAdd = 1'b1;
    i2.start      = 1'b1;
    tick();
    i2.start = 1'b0;
    waitDone(2, cyc, nd);
    chk("w8_lat",  64'(cyc),     64'd4);
    chk("w8_s",    64'(i2.s),    64'h7F);
    chk("w8_ovf",  64'(i2.ovf),  64'd1);
    chk("w8_c",    64'(i2.c),    64'd1);
    chk("w8_zero", 64'(i2.zero), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
